// File: rtl/popcount_frame_accumulator.sv
// popcount_frame_accumulator
// Registers the popcount of each accepted 7-bit word and sums the counts over
// a frame of up to FRAME_LEN words. The frame total is presented on a
// valid/ready output port.
// Optional feature macro: POPCNT_ACC_SATURATE_EN. When it is defined, the
// accumulator clamps at 2^ACC_W-1 and sets a sticky saturation flag. When it
// is not defined, the accumulator wraps and out_sat is tied to 0.
//
// state | meaning
// ACCUM | accepting words, accumulating registered popcounts
// DRAIN | last word accepted, its popcount is being added
// HOLD  | frame result presented, waiting for out_ready
module popcount_frame_accumulator #(
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_bits,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic [7:0]       out_words,
    output logic             out_sat
);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   pc_q, pc_d;
    logic               pc_v_q, pc_v_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         word_cnt_q, word_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_count_q, out_count_d;
    logic [7:0]         out_words_q, out_words_d;
`ifdef POPCNT_ACC_SATURATE_EN
    logic               sat_q, sat_d;
    logic               out_sat_q, out_sat_d;
    logic [ACC_W:0]     sum;
`endif

    logic               in_hs;
    logic               out_hs;
    logic               last_word;
    logic [2:0]         pc_new;

    // Ones count of the incoming word.
    always_comb begin
        pc_new = 3'd0;
        for (int i = 0; i < 7; i++) begin
            pc_new = pc_new + {2'b00, in_bits[i]};
        end
    end

    assign in_ready  = (state_q == ACCUM) && !rst;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;
    assign last_word = in_last || (word_cnt_q == 8'(FRAME_LEN - 1));

    // Next-state, pipe stage, accumulator and output register computation.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_v_d      = 1'b0;
        acc_d       = acc_q;
        word_cnt_d  = word_cnt_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_words_d = out_words_q;
`ifdef POPCNT_ACC_SATURATE_EN
        sat_d       = sat_q;
        out_sat_d   = out_sat_q;
        sum         = {1'b0, acc_q} + {1'b0, pc_q};
`endif

        if (in_hs) begin
            pc_d       = ACC_W'(pc_new);
            pc_v_d     = 1'b1;
            word_cnt_d = word_cnt_q + 8'd1;
        end

        if (pc_v_q) begin
`ifdef POPCNT_ACC_SATURATE_EN
            // Once clamped, acc sits at all-ones, so further adds keep it there.
            if (sum[ACC_W]) begin
                acc_d = '1;
                sat_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
`else
            acc_d = acc_q + pc_q;
`endif
        end

        case (state_q)
            ACCUM: begin
                if (in_hs && last_word) begin
                    state_d     = DRAIN;
                    out_words_d = word_cnt_q + 8'd1;
                end
            end
            DRAIN: begin
                // The last word's popcount is in pc_q now; capture the final sum.
                state_d     = HOLD;
                out_valid_d = 1'b1;
                out_count_d = acc_d;
`ifdef POPCNT_ACC_SATURATE_EN
                out_sat_d   = sat_d;
`endif
            end
            HOLD: begin
                if (out_hs) begin
                    state_d     = ACCUM;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    word_cnt_d  = 8'd0;
`ifdef POPCNT_ACC_SATURATE_EN
                    sat_d       = 1'b0;
                    out_sat_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            pc_q        <= '0;
            pc_v_q      <= 1'b0;
            acc_q       <= '0;
            word_cnt_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_words_q <= 8'd0;
`ifdef POPCNT_ACC_SATURATE_EN
            sat_q       <= 1'b0;
            out_sat_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_v_q      <= pc_v_d;
            acc_q       <= acc_d;
            word_cnt_q  <= word_cnt_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_words_q <= out_words_d;
`ifdef POPCNT_ACC_SATURATE_EN
            sat_q       <= sat_d;
            out_sat_q   <= out_sat_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_words = out_words_q;
`ifdef POPCNT_ACC_SATURATE_EN
    assign out_sat   = out_sat_q;
`else
    assign out_sat   = 1'b0;
`endif

endmodule

// File: doc/popcount_frame_accumulator.md
# popcount_frame_accumulator

Streaming stage directly downstream of the 7-input popcount adder tree. It accepts one 7-bit vector per valid/ready handshake and registers its popcount (0..7) in a one-stage pipeline. It sums those counts over a frame of up to FRAME_LEN words and presents the frame total on a valid/ready output port. Used wherever per-word ones-counts are aggregated into per-frame statistics.

## Interface
- FRAME_LEN, 16: words per frame when in_last is not asserted earlier; legal range 2..255.
- ACC_W, 8: accumulator/output width; ≥3. Default holds the worst case 7*16=112.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset is synchronous and active-high; sampled on clk rising edge.
- in_valid  in  1  in_bits valid.
- in_ready  out  1  block can accept; combinational = (state==ACCUM) && !rst.
- in_bits  in  7  vector whose set bits are counted.
- in_last  in  1  marks final word of a short frame; ignored unless handshake occurs.
- out_valid  out  1  frame result held stable.
- out_ready  in  1  consumer accepts result.
- out_count  out  ACC_W  sum of popcounts of all words in the frame.
- out_words  out  8  number of words accepted in the frame (1..FRAME_LEN).
- out_sat  out  1  frame total was clamped (see Configuration).

## Operation
- Input handshake fires on a rising edge with in_valid && in_ready. Output handshake fires with out_valid && out_ready.
- Pipe stage: on input handshake, pc_q <= popcount(in_bits), zero-extended to ACC_W, and pc_v <= 1. Otherwise pc_v <= 0.
- Accumulate: each edge with pc_v=1, acc <= acc + pc_q, per the arithmetic rule below.
- word_cnt increments on each input handshake. The word is last if in_last=1 or word_cnt==FRAME_LEN-1.
- FSM states:
  - ACCUM: in_ready=1, out_valid=0. Handshake of the last word -> DRAIN; out_words <= word_cnt+1.
  - DRAIN: in_ready=0. The final pc_q is added -> HOLD unconditionally.
  - HOLD: out_valid=1; out_count=acc and out_sat are stable. On output handshake: acc, word_cnt and sat flag clear -> ACCUM.
- Arithmetic: popcount width 3 bits. Sum computed ACC_W+1 bits wide. Overflow is bit ACC_W of that sum.
- A single-word frame (in_last on the first word) is legal: out_words=1.
- in_valid with in_ready=0 is a no-op; upstream must hold data.
- Reset values: state=ACCUM, acc=0, pc_q=0, pc_v=0, word_cnt=0, out_valid=0, out_count=0, out_words=0, out_sat=0. in_ready is 0 while rst=1 and 1 in the first cycle after.
- Reset mid-frame, in DRAIN, or in HOLD discards the frame with no output. An input handshake in the reset cycle is not taken.

## Timing
- Last-word handshake at edge E0 -> DRAIN after E0 -> HOLD with out_valid=1 after E0+1. Latency is 2 cycles.
- Output handshake at edge H -> ACCUM after H. in_ready=1 in the cycle after H. Minimum frame period is N+2 cycles for N words with out_ready held high.
- Back-to-back input words in ACCUM sustain 1 word/cycle.
- out_* registered. Only in_ready is combinational (from state and rst).

## Configuration
- POPCNT_ACC_SATURATE_EN defined:
  - On overflow, acc clamps to 2^ACC_W-1 and the sticky sat flag sets.
  - out_sat reports the flag in HOLD. The flag clears on output handshake or rst.
- Not defined:
  - acc wraps modulo 2^ACC_W.
  - out_sat is constant 0.

## Test plan
- Defaults; 16 words of 7'h7F, out_ready=1 -> out_valid 2 cycles after 16th handshake; out_count=112, out_words=16, out_sat=0; in_ready=1 the cycle after output handshake.
- Words 7'h01, 7'h03, 7'h55 (in_last on third) -> out_count=7, out_words=3. in_ready=0 during DRAIN and HOLD.
- Single word 7'h00 with in_last -> out_count=0, out_words=1. out_ready low 5 cycles -> out_valid/out_count held stable, in_valid ignored.
- ACC_W=6, 16 words of 7'h7F:
  - With POPCNT_ACC_SATURATE_EN: out_count=63, out_sat=1.
  - Without: out_count=112 mod 64=48, out_sat=0.
- rst pulsed after 5 words of 7'h0F -> out_valid stays 0. Next frame of 16 words of 7'h01 reports out_count=16, out_words=16.
- rst asserted while out_valid=1 -> out_valid=0 the next cycle and no output handshake completes.
